// File: rtl/alu_mc_pkg.sv
// Shared constants for the multi-cycle ALU: opcode map, FSM state encoding
// and the shift-amount width helper.
package alu_mc_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_MUL  = 4'b0110;
  localparam logic [3:0] OP_XOR  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bits needed to express an in-range shift amount for a given width.
  function automatic int shamt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle for alu_mc.
//   master: issue side (drives operands, op, in_valid, out_ready)
//   slave : the ALU (drives in_ready, out_valid, result, zero_flag)
interface alu_mc_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [3:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero_flag;

  modport master (
    output in_valid, a_in, b_in, op, out_ready,
    input  in_ready, out_valid, result, zero_flag
  );

  modport slave (
    input  in_valid, a_in, b_in, op, out_ready,
    output in_ready, out_valid, result, zero_flag
  );
endinterface

// File: rtl/alu_mc_iter_muldiv.sv
// Iterative engine: shift-add multiplier, one multiplier bit per cycle over
// WIDTH cycles. With ALU_MC_DIV_EN defined it also runs restoring division
// (quotient or remainder) over the same WIDTH cycles.
// Ports:
//   clk, reset  clock / async active-high reset
//   start_i     load operands and begin (ignored while busy)
//   div_i/rem_i (ALU_MC_DIV_EN only) select DIVU / REMU instead of MUL
//   a_i, b_i    operands (multiplicand/multiplier or dividend/divisor)
//   done_o      one-cycle pulse during the final iteration
//   res_o       final result, valid while done_o is high
module alu_iter_muldiv
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
`ifdef ALU_MC_DIV_EN
  input  logic             div_i,
  input  logic             rem_i,
`endif
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] res_o
);
  localparam int CNT_W = shamt_w(WIDTH);

  logic             busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // acc: product accumulator / partial remainder
  // x  : multiplicand (shifted left each step) / divisor
  // y  : multiplier (shifted right) / dividend shifting out, quotient in
  logic [WIDTH-1:0] acc_q, acc_d, x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] acc_step, x_step, y_step;
`ifdef ALU_MC_DIV_EN
  logic             div_q, div_d, rem_q, rem_d;
  logic [WIDTH:0]   sh;
  logic             ge;
`endif

  always_comb begin
    acc_step = acc_q + (y_q[0] ? x_q : '0);
    x_step   = x_q << 1;
    y_step   = y_q >> 1;
`ifdef ALU_MC_DIV_EN
    // Explicit compare (not subtract sign) so a zero divisor still gives
    // quotient all-ones and remainder equal to the dividend.
    sh = {acc_q, y_q[WIDTH-1]};
    ge = (sh >= {1'b0, x_q});
    if (div_q) begin
      acc_step = ge ? (sh[WIDTH-1:0] - x_q) : sh[WIDTH-1:0];
      x_step   = x_q;
      y_step   = {y_q[WIDTH-2:0], ge};
    end
`endif
  end

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    x_d    = x_q;
    y_d    = y_q;
`ifdef ALU_MC_DIV_EN
    div_d  = div_q;
    rem_d  = rem_q;
`endif
    if (busy_q) begin
      acc_d = acc_step;
      x_d   = x_step;
      y_d   = y_step;
      cnt_d = cnt_q + 1'b1;
      if (done_o) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end
    end else if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      acc_d  = '0;
      x_d    = b_i;
      y_d    = a_i;
`ifdef ALU_MC_DIV_EN
      div_d  = div_i | rem_i;
      rem_d  = rem_i;
`endif
    end
  end

  always_comb begin
    done_o = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    res_o  = acc_step;
`ifdef ALU_MC_DIV_EN
    if (div_q && !rem_q) res_o = y_step;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      acc_q  <= '0;
      x_q    <= '0;
      y_q    <= '0;
`ifdef ALU_MC_DIV_EN
      div_q  <= 1'b0;
      rem_q  <= 1'b0;
`endif
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      x_q    <= x_d;
      y_q    <= y_d;
`ifdef ALU_MC_DIV_EN
      div_q  <= div_d;
      rem_q  <= rem_d;
`endif
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready on input and output. Single-cycle ops
// produce a result the cycle after accept; MUL (and DIVU/REMU when
// ALU_MC_DIV_EN is defined) run on the iterative engine, WIDTH+1 cycles.
// One op in flight; a new bundle may be accepted while a result drains.
// Ports:
//   clk, reset  clock / async active-high reset
//   bus         alu_mc_if slave: in_valid/in_ready, a_in, b_in, op,
//               out_valid/out_ready, result, zero_flag
// Optional feature macro: ALU_MC_DIV_EN
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     reset,
  alu_mc_if.slave  bus
);
  localparam int SHAMT_W = shamt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             out_valid_q, out_valid_d;

  logic             accept, iter_op, eng_start, eng_done, shift_oor;
  logic [WIDTH-1:0] eng_res, alu_res;
  logic [SHAMT_W-1:0] shamt;

  assign bus.in_ready  = (state_q == ST_IDLE) || (state_q == ST_DONE && bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero_flag = zero_q;

  assign accept    = bus.in_valid && bus.in_ready;
  assign eng_start = accept && iter_op;

  always_comb begin
    iter_op = (bus.op == OP_MUL);
`ifdef ALU_MC_DIV_EN
    iter_op = iter_op || (bus.op == OP_DIVU) || (bus.op == OP_REMU);
`endif
  end

  alu_iter_muldiv #(.WIDTH(WIDTH)) u_iter (
    .clk     (clk),
    .reset   (reset),
    .start_i (eng_start),
`ifdef ALU_MC_DIV_EN
    .div_i   (bus.op == OP_DIVU),
    .rem_i   (bus.op == OP_REMU),
`endif
    .a_i     (bus.a_in),
    .b_i     (bus.b_in),
    .done_o  (eng_done),
    .res_o   (eng_res)
  );

  // Any set bit above the in-range shift field means b_in >= WIDTH.
  assign shift_oor = |bus.b_in[WIDTH-1:SHAMT_W];
  assign shamt     = bus.b_in[SHAMT_W-1:0];

  always_comb begin
    alu_res = '0;
    case (bus.op)
      OP_AND:  alu_res = bus.a_in & bus.b_in;
      OP_OR:   alu_res = bus.a_in | bus.b_in;
      OP_XOR:  alu_res = bus.a_in ^ bus.b_in;
      OP_ADD:  alu_res = bus.a_in + bus.b_in;
      OP_SUB:  alu_res = bus.a_in - bus.b_in;
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a_in < bus.b_in)};
      OP_SLL:  alu_res = shift_oor ? '0 : (bus.a_in << shamt);
      OP_SRL:  alu_res = shift_oor ? '0 : (bus.a_in >> shamt);
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    zero_d      = zero_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (state_q == ST_DONE && bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
        end
        if (accept) begin
          if (iter_op) begin
            state_d     = ST_BUSY;
            out_valid_d = 1'b0;
          end else begin
            state_d     = ST_DONE;
            result_d    = alu_res;
            zero_d      = (alu_res == '0);
            out_valid_d = 1'b1;
          end
        end
      end
      ST_BUSY: begin
        if (eng_done) begin
          state_d     = ST_DONE;
          result_d    = eng_res;
          zero_d      = (eng_res == '0);
          out_valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32): vector table, hand-written
// handshake/reset sequences, then random ops against a reference model.
module tb_alu_mc;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_mc_if #(.WIDTH(W)) bus();
  alu_mc #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] res;
    logic         zf;
    int           lat;
    string        name;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: the opcode map written as plain arithmetic.
  function automatic logic [W-1:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [3:0] op);
    logic [63:0] p;
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0100: return a - b;
      4'b1000: return (a < b) ? 1 : 0;
      4'b0011: return (b >= W) ? 0 : (a << b);
      4'b0101: return (b >= W) ? 0 : (a >> b);
      4'b0110: begin p = {32'd0, a} * {32'd0, b}; return p[W-1:0]; end
      4'b0111: return a ^ b;
`ifdef ALU_MC_DIV_EN
      4'b1001: return (b == 0) ? '1 : a / b;
      4'b1010: return (b == 0) ? a : a % b;
`endif
      default: return 0;
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    if (op == 4'b0110) return W + 1;
`ifdef ALU_MC_DIV_EN
    if (op == 4'b1001 || op == 4'b1010) return W + 1;
`endif
    return 1;
  endfunction

  // Issue one op from idle with out_ready=1; measure cycles to out_valid.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                        input logic [W-1:0] eres, input logic ezf, input int elat,
                        input string name);
    int cyc;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a_in = a; bus.b_in = b; bus.op = op; bus.out_ready = 1'b1;
    check({name, " in_ready"}, W'(bus.in_ready), 1);
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    cyc = 0;
    while (cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) break;
    end
    check({name, " latency"}, W'(cyc), W'(elat));
    check({name, " result"}, bus.result, eres);
    check({name, " zero_flag"}, W'(bus.zero_flag), W'(ezf));
  endtask

  logic [W-1:0] ba[3], bb[3];
  logic [3:0]   bo[3];
  logic [3:0]   rops[11];
  logic [W-1:0] ra, rb, rr;
  logic [3:0]   rop;
  logic         saw_valid;

  initial begin
    bus.in_valid = 1'b0; bus.a_in = '0; bus.b_in = '0; bus.op = '0; bus.out_ready = 1'b0;

    vecs.push_back('{32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b1, 1, "add_wrap"});
    vecs.push_back('{32'h0001_0000, 32'h0001_0000, 4'b0110, 32'd0, 1'b1, W + 1, "mul_ovf"});
    vecs.push_back('{32'd12, 32'd13, 4'b0110, 32'd156, 1'b0, W + 1, "mul_12_13"});
    vecs.push_back('{32'd3, 32'd5, 4'b1000, 32'd1, 1'b0, 1, "sltu_lt"});
    vecs.push_back('{32'd5, 32'd3, 4'b1000, 32'd0, 1'b1, 1, "sltu_ge"});
    vecs.push_back('{32'd1, 32'd32, 4'b0011, 32'd0, 1'b1, 1, "sll_32"});
    vecs.push_back('{32'd1, 32'd31, 4'b0011, 32'h8000_0000, 1'b0, 1, "sll_31"});
    vecs.push_back('{32'h8000_0000, 32'd4, 4'b0101, 32'h0800_0000, 1'b0, 1, "srl_4"});
    vecs.push_back('{32'hF0F0_1234, 32'h0FF0_FFFF, 4'b0000, 32'h00F0_1234, 1'b0, 1, "and"});
    vecs.push_back('{32'h1234_5678, 32'h1234_5678, 4'b0100, 32'd0, 1'b1, 1, "sub_zero"});
    vecs.push_back('{32'hDEAD_BEEF, 32'h1, 4'b1011, 32'd0, 1'b1, 1, "undef_1011"});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0110, 32'd1, 1'b0, W + 1, "mul_ones"});
`ifdef ALU_MC_DIV_EN
    vecs.push_back('{32'd100, 32'd7, 4'b1001, 32'd14, 1'b0, W + 1, "divu_100_7"});
    vecs.push_back('{32'd100, 32'd7, 4'b1010, 32'd2, 1'b0, W + 1, "remu_100_7"});
    vecs.push_back('{32'h8765_4321, 32'd0, 4'b1001, 32'hFFFF_FFFF, 1'b0, W + 1, "divu_by0"});
    vecs.push_back('{32'h8765_4321, 32'd0, 4'b1010, 32'h8765_4321, 1'b0, W + 1, "remu_by0"});
`else
    vecs.push_back('{32'd100, 32'd7, 4'b1001, 32'd0, 1'b1, 1, "divu_undef"});
    vecs.push_back('{32'd100, 32'd7, 4'b1010, 32'd0, 1'b1, 1, "remu_undef"});
`endif

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst out_valid", W'(bus.out_valid), 0);
    check("rst result", bus.result, 0);
    check("rst zero_flag", W'(bus.zero_flag), 0);
    reset = 1'b0;
    @(negedge clk);
    check("rst in_ready", W'(bus.in_ready), 1);

    foreach (vecs[i])
      run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res, vecs[i].zf, vecs[i].lat, vecs[i].name);

    // Backpressure: SUB 5-7 held while out_ready=0.
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a_in = 32'd5; bus.b_in = 32'd7; bus.op = 4'b0100; bus.out_ready = 1'b0;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("bp out_valid", W'(bus.out_valid), 1);
      check("bp result", bus.result, 32'hFFFF_FFFE);
      check("bp in_ready", W'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp drained", W'(bus.out_valid), 0);
    check("bp idle in_ready", W'(bus.in_ready), 1);

    // Back-to-back single-cycle ops: one result per cycle.
    ba[0] = 32'hF0F0_F0F0; bb[0] = 32'h0FF0_0FF0; bo[0] = 4'b0111;
    ba[1] = 32'h1200_0034; bb[1] = 32'h0056_7800; bo[1] = 4'b0001;
    ba[2] = 32'd3;         bb[2] = 32'd5;         bo[2] = 4'b1000;
    @(negedge clk);
    bus.in_valid = 1'b1; bus.a_in = ba[0]; bus.b_in = bb[0]; bus.op = bo[0]; bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b out_valid", W'(bus.out_valid), 1);
      check("b2b result", bus.result, ref_res(ba[i], bb[i], bo[i]));
      check("b2b in_ready", W'(bus.in_ready), 1);
      if (i < 2) begin
        bus.a_in = ba[i+1]; bus.b_in = bb[i+1]; bus.op = bo[i+1];
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    @(negedge clk);
    check("b2b drained", W'(bus.out_valid), 0);

    // Reset in the middle of a MUL.
    bus.in_valid = 1'b1; bus.a_in = 32'd7; bus.b_in = 32'd9; bus.op = 4'b0110;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst out_valid", W'(bus.out_valid), 0);
    check("midrst result", bus.result, 0);
    check("midrst zero_flag", W'(bus.zero_flag), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst in_ready", W'(bus.in_ready), 1);
    saw_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("midrst no stale result", W'(saw_valid), 0);
    run_op(32'd7, 32'd9, 4'b0110, 32'd63, 1'b0, W + 1, "mul_after_rst");

    // Random ops against the reference model.
    rops = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
             4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010};
    for (int n = 0; n < 60; n++) begin
      rop = rops[$urandom_range(0, 10)];
      if (n % 13 == 12) rop = 4'($urandom_range(11, 15));
      ra = $urandom;
      rb = $urandom;
      if (rop == 4'b0011 || rop == 4'b0101) rb = $urandom_range(0, 40);
      if (n % 9 == 4) rb = $urandom_range(0, 15);
      rr = ref_res(ra, rb, rop);
      run_op(ra, rb, rop, rr, (rr == 0), ref_lat(rop), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
